// File: rtl/imem_loader.sv
// imem_loader: program loader and run controller for the pipeline datapath.
// Holds the core in reset, streams a length-prefixed, checksummed image into
// instruction memory over a valid/ready port, writes the stack pointer through
// the register-file port, then releases the core for a fixed cycle budget.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   start_i                begin a load (accepted only in IDLE/HALT/ERR)
//   in_valid_i, in_data_i  image word stream
//   in_ready_o             loader accepts a word (HDR/DATA/SUM)
//   imem_we_o/addr_o/wdata_o  instruction memory write port (registered)
//   rf_we_o/waddr_o/wdata_o   register file write port (INIT only)
//   core_reset_o           active-high datapath reset, low only in RUN
//   busy_o, done_o, error_o, err_code_o  status
//   cycle_count_o          cycles spent in RUN
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// HDR   | expecting word count N
// DATA  | streaming N words into instruction memory
// SUM   | expecting checksum word
// INIT  | one-cycle stack pointer write
// RUN   | core released for RUN_CYCLES cycles
// HALT  | run finished, core held in reset
// ERR   | bad count or checksum, core held in reset

module imem_loader #(
  parameter int               XLEN       = 32,
  parameter int               DEPTH      = 64,
  parameter int               SP_REG     = 2,
  parameter logic [XLEN-1:0]  SP_INIT    = 32'h400,
  parameter int               RUN_CYCLES = 330,
  parameter int               CNT_W      = 32,
  localparam int              ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [XLEN-1:0]   in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [XLEN-1:0]   imem_wdata_o,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              core_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        err_code_o,
  output logic [CNT_W-1:0]  cycle_count_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_INIT = 3'd4;
  localparam logic [2:0] S_RUN  = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_SUM   = 2'd2;

  localparam logic [XLEN-1:0]   DEPTH_X   = XLEN'(DEPTH);
  localparam logic [ADDR_W:0]   LEFT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   left_q, left_d;         // data words still to come
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  run_left_q, run_left_d; // run timer, terminal count at 0
  logic [1:0]        err_q, err_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]   imem_wdata_q, imem_wdata_d;

  logic xfer;
  logic hdr_bad;

  assign in_ready_o = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_SUM);
  assign xfer       = in_valid_i && in_ready_o;
  assign hdr_bad    = (in_data_i == '0) || (in_data_i > DEPTH_X);

  always_comb begin
    state_d      = state_q;
    left_d       = left_q;
    addr_d       = addr_q;
    sum_d        = sum_q;
    cyc_d        = cyc_q;
    run_left_d   = run_left_q;
    err_d        = err_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR;
          err_d   = ERR_NONE;
          sum_d   = '0;
          addr_d  = '0;
          cyc_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (hdr_bad) begin
            state_d = S_ERR;
            err_d   = ERR_COUNT;
          end else begin
            // N <= DEPTH here, so the low ADDR_W+1 bits hold it exactly
            left_d  = in_data_i[ADDR_W:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = addr_q;
          imem_wdata_d = in_data_i;
          addr_d       = addr_q + ADDR_ONE;
          sum_d        = sum_q + in_data_i;
          left_d       = left_q - LEFT_ONE;
          if (left_q == LEFT_ONE) begin
            state_d = S_SUM;
          end
        end
      end
      S_SUM: begin
        if (xfer) begin
          if (in_data_i == sum_q) begin
            state_d = S_INIT;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_SUM;
          end
        end
      end
      S_INIT: begin
        run_left_d = RUN_LAST;
        state_d    = S_RUN;
      end
      S_RUN: begin
        cyc_d = cyc_q + CNT_ONE;
        if (run_left_q == '0) begin
          state_d = S_HALT;
        end else begin
          run_left_d = run_left_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      left_q       <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      cyc_q        <= '0;
      run_left_q   <= '0;
      err_q        <= ERR_NONE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      addr_q       <= addr_d;
      sum_q        <= sum_d;
      cyc_q        <= cyc_d;
      run_left_q   <= run_left_d;
      err_q        <= err_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we_o     = imem_we_q;
  assign imem_addr_o   = imem_addr_q;
  assign imem_wdata_o  = imem_wdata_q;

  assign rf_we_o       = (state_q == S_INIT);
  assign rf_waddr_o    = rf_we_o ? 5'(SP_REG) : 5'd0;
  assign rf_wdata_o    = rf_we_o ? SP_INIT : '0;

  assign core_reset_o  = (state_q != S_RUN);
  assign done_o        = (state_q == S_HALT);
  assign error_o       = (state_q == S_ERR);
  assign busy_o        = !((state_q == S_IDLE) || done_o || error_o);
  assign err_code_o    = err_q;
  assign cycle_count_o = cyc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed image loads checked cycle by cycle
// against a transaction-level model of the load/run protocol, plus literal
// expectations on memory contents, register writes and run length.

module tb_imem_loader;

  localparam int DEPTH      = 64;
  localparam int RUN_CYCLES = 330;

  logic        clk_i      = 1'b0;
  logic        rst_ni     = 1'b0;
  logic        start_i    = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i  = '0;
  logic        in_ready_o;
  logic        imem_we_o;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        core_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  err_code_o;
  logic [31:0] cycle_count_o;

  imem_loader #(
    .XLEN(32), .DEPTH(DEPTH), .SP_REG(2), .SP_INIT(32'h400),
    .RUN_CYCLES(RUN_CYCLES), .CNT_W(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .core_reset_o(core_reset_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .err_code_o(err_code_o), .cycle_count_o(cycle_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Protocol model: phase of the load, words seen, running sum, run cycles.
  typedef enum int {PH_IDLE, PH_HDR, PH_DATA, PH_SUM, PH_INIT, PH_RUN, PH_HALT, PH_ERR} ph_t;
  ph_t         m_ph;
  int          m_n, m_addr, m_cyc, m_waddr;
  logic [31:0] m_sum, m_wdata;
  logic [1:0]  m_err;
  logic        m_we;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_ph <= PH_IDLE; m_n <= 0; m_addr <= 0; m_cyc <= 0; m_sum <= '0;
      m_err <= 2'd0; m_we <= 1'b0; m_waddr <= 0; m_wdata <= '0;
    end else begin
      m_we <= 1'b0;
      case (m_ph)
        PH_IDLE, PH_HALT, PH_ERR:
          if (start_i) begin
            m_ph <= PH_HDR; m_err <= 2'd0; m_sum <= '0; m_addr <= 0; m_cyc <= 0;
          end
        PH_HDR:
          if (in_valid_i) begin
            if (in_data_i == 0 || in_data_i > DEPTH) begin
              m_ph <= PH_ERR; m_err <= 2'd1;
            end else begin
              m_n <= int'(in_data_i); m_ph <= PH_DATA;
            end
          end
        PH_DATA:
          if (in_valid_i) begin
            m_we <= 1'b1; m_waddr <= m_addr; m_wdata <= in_data_i;
            m_addr <= m_addr + 1; m_sum <= m_sum + in_data_i;
            if (m_addr + 1 == m_n) m_ph <= PH_SUM;
          end
        PH_SUM:
          if (in_valid_i) begin
            if (in_data_i == m_sum) m_ph <= PH_INIT;
            else begin m_ph <= PH_ERR; m_err <= 2'd2; end
          end
        PH_INIT: m_ph <= PH_RUN;
        PH_RUN: begin
          m_cyc <= m_cyc + 1;
          if (m_cyc + 1 == RUN_CYCLES) m_ph <= PH_HALT;
        end
        default: m_ph <= PH_IDLE;
      endcase
    end
  end

  // Observed side effects, tallied for end-of-scenario checks.
  logic [31:0] obs_mem [DEPTH];
  int          n_wr = 0, n_rf = 0, n_run = 0;
  logic [31:0] obs_rf_data = '0;
  logic [4:0]  obs_rf_addr = '0;

  always @(negedge clk_i) begin
    chk("in_ready",    32'(in_ready_o),   32'(m_ph inside {PH_HDR, PH_DATA, PH_SUM}));
    chk("core_reset",  32'(core_reset_o), 32'(m_ph != PH_RUN));
    chk("busy",        32'(busy_o),       32'(!(m_ph inside {PH_IDLE, PH_HALT, PH_ERR})));
    chk("done",        32'(done_o),       32'(m_ph == PH_HALT));
    chk("error",       32'(error_o),      32'(m_ph == PH_ERR));
    chk("err_code",    32'(err_code_o),   32'(m_err));
    chk("cycle_count", cycle_count_o,     32'(m_cyc));
    chk("imem_we",     32'(imem_we_o),    32'(m_we));
    if (m_we) begin
      chk("imem_addr",  32'(imem_addr_o), 32'(m_waddr));
      chk("imem_wdata", imem_wdata_o,     m_wdata);
    end
    chk("rf_we", 32'(rf_we_o), 32'(m_ph == PH_INIT));
    if (m_ph == PH_INIT) begin
      chk("rf_waddr", 32'(rf_waddr_o), 32'd2);
      chk("rf_wdata", rf_wdata_o,      32'h400);
    end
    if (imem_we_o) begin
      obs_mem[imem_addr_o] <= imem_wdata_o;
      n_wr <= n_wr + 1;
    end
    if (rf_we_o) begin
      n_rf <= n_rf + 1; obs_rf_data <= rf_wdata_o; obs_rf_addr <= rf_waddr_o;
    end
    if (!core_reset_o) n_run <= n_run + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int gap, input logic pulse);
    in_valid_i = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start_i = pulse;
      tick();
    end
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    for (int i = 0; i < 20; i++) begin
      if (in_ready_o) begin
        tick();
        in_valid_i = 1'b0;
        return;
      end
      tick();
    end
    in_valid_i = 1'b0;
    fail_now("send_word");
  endtask

  task automatic wait_end(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_o || error_o) return;
      tick();
    end
    fail_now("wait_end");
  endtask

  logic [31:0] img [$];

  task automatic load(input logic [31:0] sum, input int maxgap, input logic pulse);
    do_start();
    send_word(32'(img.size()), 0, 1'b0);
    foreach (img[i]) send_word(img[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0, pulse);
    send_word(sum, 0, 1'b0);
  endtask

  int wr0, rf0, run0;
  logic [31:0] big_sum;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while inputs toggle
    rst_ni = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start_i    = i[0];
      in_valid_i = i[1];
      in_data_i  = 32'h55 * i;
      tick();
    end
    start_i = 1'b0; in_valid_i = 1'b0;
    chk("rst_in_ready",   32'(in_ready_o),   32'd0);
    chk("rst_core_reset", 32'(core_reset_o), 32'd1);
    chk("rst_imem_we",    32'(imem_we_o),    32'd0);
    chk("rst_imem_addr",  32'(imem_addr_o),  32'd0);
    chk("rst_imem_wdata", imem_wdata_o,      32'd0);
    chk("rst_rf_we",      32'(rf_we_o),      32'd0);
    chk("rst_rf_wdata",   rf_wdata_o,        32'd0);
    chk("rst_busy",       32'(busy_o),       32'd0);
    chk("rst_cycles",     cycle_count_o,     32'd0);
    rst_ni = 1'b1;
    tick();

    // Good image
    img = '{32'hfd010113, 32'h02812623, 32'h03010413};
    wr0 = n_wr; rf0 = n_rf; run0 = n_run;
    load(32'h02832B49, 0, 1'b0);
    chk("model_sum", m_sum, 32'h02832B49);
    wait_end(800);
    chk("good_done",     32'(done_o),   32'd1);
    chk("good_cycles",   cycle_count_o, 32'd330);
    chk("good_writes",   32'(n_wr - wr0), 32'd3);
    chk("good_mem0",     obs_mem[0],    32'hfd010113);
    chk("good_mem1",     obs_mem[1],    32'h02812623);
    chk("good_mem2",     obs_mem[2],    32'h03010413);
    chk("good_rf_count", 32'(n_rf - rf0), 32'd1);
    chk("good_rf_addr",  32'(obs_rf_addr), 32'd2);
    chk("good_rf_data",  obs_rf_data,   32'h400);
    chk("good_run_len",  32'(n_run - run0), 32'd330);

    // Bad checksum, then a reload
    rf0 = n_rf; run0 = n_run;
    load(32'h02832B48, 0, 1'b0);
    wait_end(50);
    chk("badsum_error", 32'(error_o),    32'd1);
    chk("badsum_code",  32'(err_code_o), 32'd2);
    chk("badsum_rf",    32'(n_rf - rf0), 32'd0);
    chk("badsum_run",   32'(n_run - run0), 32'd0);
    load(32'h02832B49, 0, 1'b0);
    wait_end(800);
    chk("reload_done",  32'(done_o),     32'd1);
    chk("reload_code",  32'(err_code_o), 32'd0);

    // Bad counts
    wr0 = n_wr;
    do_start();
    send_word(32'd0, 0, 1'b0);
    wait_end(20);
    chk("hdr0_code", 32'(err_code_o), 32'd1);
    do_start();
    send_word(32'd65, 0, 1'b0);
    wait_end(20);
    chk("hdr65_code",   32'(err_code_o), 32'd1);
    chk("hdr_bad_wr",   32'(n_wr - wr0), 32'd0);

    // 41-word image with stalls and ignored start pulses
    img.delete();
    big_sum = '0;
    for (int i = 0; i < 41; i++) begin
      img.push_back(32'h1000_0000 + 32'h0101_0101 * i);
      big_sum = big_sum + (32'h1000_0000 + 32'h0101_0101 * i);
    end
    wr0 = n_wr;
    load(big_sum, 3, 1'b1);
    wait_end(800);
    chk("stall_done",   32'(done_o),     32'd1);
    chk("stall_writes", 32'(n_wr - wr0), 32'd41);
    chk("stall_mem0",   obs_mem[0],      32'h1000_0000);
    chk("stall_mem40",  obs_mem[40],     32'h3828_2828);

    // Mid-load reset after the 2nd data word
    do_start();
    send_word(32'd5, 0, 1'b0);
    send_word(32'hAAAA_0001, 0, 1'b0);
    send_word(32'hAAAA_0002, 0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_in_ready",   32'(in_ready_o),   32'd0);
    chk("midrst_core_reset", 32'(core_reset_o), 32'd1);
    chk("midrst_busy",       32'(busy_o),       32'd0);
    chk("midrst_imem_we",    32'(imem_we_o),    32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    img = '{32'hfd010113, 32'h02812623, 32'h03010413};
    load(32'h02832B49, 0, 1'b0);
    wait_end(800);
    chk("after_rst_done",   32'(done_o),   32'd1);
    chk("after_rst_cycles", cycle_count_o, 32'd330);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised program loader and run controller for the RISC-V pipeline datapath. It holds the core in reset and streams a length-prefixed, checksummed program image into instruction memory through a valid/ready port. It then initialises the stack pointer through the register-file write port and releases the core for a fixed cycle budget. It replaces hierarchical back-door memory/register pokes and fixed simulation delays, so the same image path serves simulation and FPGA bring-up.

## Interface
- XLEN, 32, data/instruction word width
- DEPTH, 64, instruction memory depth in words; ADDR_W = $clog2(DEPTH) (localparam)
- SP_REG, 2, register index written at init
- SP_INIT, 32'h400, value written to SP_REG
- RUN_CYCLES, 330, core run budget in clock cycles (>=1)
- CNT_W, 32, cycle counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- start  in  1  begin load; honoured only in IDLE, HALT, ERR
- in_valid  in  1  image word valid
- in_data  in  XLEN  image word
- in_ready  out  1  loader accepts word; transfer = in_valid & in_ready
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  XLEN  write data
- rf_we  out  1  register file write strobe
- rf_waddr  out  5  register index
- rf_wdata  out  XLEN  register write data
- core_reset  out  1  active-high reset to datapath
- busy  out  1  state not in {IDLE, HALT, ERR}
- done  out  1  state == HALT
- error  out  1  state == ERR
- err_code  out  2  0 none, 1 bad count, 2 checksum mismatch
- cycle_count  out  CNT_W  core cycles elapsed in RUN

## Operation
- States: IDLE, HDR, DATA, SUM, INIT, RUN, HALT, ERR.
- IDLE/HALT/ERR + start -> HDR; clears err_code, checksum, word address, cycle_count. start is ignored in every other state.
- in_ready = 1 in HDR, DATA and SUM; 0 otherwise.
- HDR: on transfer, N = in_data. If N == 0 or N > DEPTH -> ERR with err_code 1; else -> DATA.
- DATA: each transfer registers imem_we = 1, imem_addr = current address, imem_wdata = in_data for the next cycle.
  - Address starts at 0 and increments by 1 per word.
  - checksum += in_data, modulo 2^XLEN.
  - After the Nth word -> SUM.
- SUM: on transfer, in_data == checksum -> INIT; else -> ERR with err_code 2. No memory write.
- INIT: one cycle with rf_we = 1, rf_waddr = SP_REG, rf_wdata = SP_INIT -> RUN.
- RUN: core_reset = 0; cycle_count increments each cycle. After exactly RUN_CYCLES cycles in RUN -> HALT.
- HALT: core_reset = 1; cycle_count holds RUN_CYCLES.
- ERR: core_reset = 1; err_code holds until the next start.
- core_reset = 1 in every state except RUN.
- Memory writes to addresses >= N from previous loads are left untouched.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, rf_we 0, rf_waddr 0, rf_wdata 0, core_reset 1, busy 0, done 0, error 0, err_code 0, cycle_count 0.
- Reset asserted mid-operation forces these values immediately, in any state; a partial image stays in memory.
- start sampled high at edge k -> HDR from k+1; in_ready high from k+1.
- Data transfer at edge t -> imem_we high during cycle t+1, for exactly one cycle per word.
- Back-to-back words give consecutive write cycles. in_valid gaps stall without side effects.
- Checksum transfer at edge s -> INIT during cycle s+1 (rf_we high) -> RUN from s+2.
- Images longer than N words: excess words are taken as the checksum, which fails unless equal.

## Test plan
- Reset: hold reset = 0, toggle start/in_valid -> all outputs at reset values, in_ready 0, core_reset 1.
- Good image: start; stream 3, 0xfd010113, 0x02812623, 0x03010413, checksum 0x02832B49 -> three imem writes at addr 0, 1, 2 with matching data; one rf_we with x2 = 0x400; core_reset low for exactly 330 cycles; then done 1, cycle_count 330.
- Bad checksum: same image with checksum 0x02832B48 -> error 1, err_code 2, no rf_we, core_reset stays 1; start then reloads successfully.
- Bad count: header 0 -> err_code 1; header DEPTH+1 (65) -> err_code 1; no imem writes in either case.
- Stalls and protocol: random in_valid gaps during a 41-word image -> addresses 0..40 written in order, checksum accepted; start pulses while busy are ignored.
- Mid-load reset: assert reset after the 2nd data word -> immediate IDLE, core_reset 1, in_ready 0; a subsequent full load completes normally.
